// File: rtl/chip8_mem_sched.sv
// Boot sequencer and access scheduler for the CHIP-8 4096x8 single-port memory.
// Optional write protection of the low region is enabled by CHIP8_MEM_WRITE_PROTECT_EN.
module chip8_mem_sched #(
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] FONT_BASE   = ADDR_W'(12'h000),
  parameter logic [ADDR_W-1:0] PROTECT_TOP = ADDR_W'(12'h1FF)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rom_req,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_wdata,
  input  logic              rom_done,
  output logic              rom_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_ack,
  output logic [7:0]        aux_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              font_ready,
  output logic              system_ready,
  output logic              prot_err
);

`ifdef CHIP8_MEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam logic [7:0] FONT_TBL [0:79] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [1:0] {ST_FONT, ST_ROM, ST_RUN} state_t;
  typedef enum logic [1:0] {OWN_ROM, OWN_CPU, OWN_AUX} owner_t;

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    return FONT_TBL[idx];
  endfunction

  state_t              r_state, w_state;
  owner_t              r_owner, w_owner;
  logic [6:0]          r_font_idx, w_font_idx;
  logic                r_issue, w_issue;
  logic                r_last_grant, w_last_grant;   // 1 = aux was granted last
  logic                r_done_pend, w_done_pend;
  logic                r_mem_en, w_mem_en;
  logic                r_mem_we, w_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic [7:0]          r_mem_wdata, w_mem_wdata;
  logic                r_rom_ack, w_rom_ack;
  logic                r_cpu_ack, w_cpu_ack;
  logic                r_aux_ack, w_aux_ack;
  logic                r_font_ready, w_font_ready;
  logic                r_sys_ready, w_sys_ready;
  logic                r_prot_err, w_prot_err;
  logic                w_cpu_go, w_aux_go, w_pick_cpu, w_prot_hit;

  // A requester whose ack is showing this cycle is still holding its request; mask it.
  assign w_cpu_go   = cpu_req & ~r_cpu_ack;
  assign w_aux_go   = aux_req & ~r_aux_ack;
  assign w_pick_cpu = w_cpu_go & (~w_aux_go | r_last_grant);
  assign w_prot_hit = WP_EN & cpu_we & (cpu_addr <= PROTECT_TOP);

  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_font_idx   = r_font_idx;
    w_issue      = 1'b0;
    w_last_grant = r_last_grant;
    w_done_pend  = r_done_pend;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_rom_ack    = 1'b0;
    w_cpu_ack    = 1'b0;
    w_aux_ack    = 1'b0;
    w_font_ready = r_font_ready | (r_state != ST_FONT);
    w_sys_ready  = r_sys_ready;
    w_prot_err   = r_prot_err;

    if (r_issue) begin
      case (r_owner)
        OWN_ROM: w_rom_ack = 1'b1;
        OWN_CPU: w_cpu_ack = 1'b1;
        OWN_AUX: w_aux_ack = 1'b1;
        default: ;
      endcase
    end

    case (r_state)
      ST_FONT: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = FONT_BASE + ADDR_W'(r_font_idx);
        w_mem_wdata = font_byte(r_font_idx);
        if (r_font_idx == 7'd79) w_state = ST_ROM;
        else                     w_font_idx = r_font_idx + 7'd1;
      end
      ST_ROM: begin
        // rom_done during an in-flight write is remembered until that write is acked.
        if (r_issue) begin
          if (rom_done) w_done_pend = 1'b1;
        end else if (rom_done || r_done_pend) begin
          w_state     = ST_RUN;
          w_done_pend = 1'b0;
          w_sys_ready = 1'b1;
        end else if (rom_req && !r_rom_ack) begin
          w_issue     = 1'b1;
          w_owner     = OWN_ROM;
          w_mem_en    = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = rom_addr;
          w_mem_wdata = rom_wdata;
        end
      end
      ST_RUN: begin
        if (!r_issue) begin
          if (w_pick_cpu) begin
            w_issue      = 1'b1;
            w_owner      = OWN_CPU;
            w_last_grant = 1'b0;
            w_mem_addr   = cpu_addr;
            w_mem_wdata  = cpu_wdata;
            if (w_prot_hit) begin
              w_prot_err = 1'b1;
            end else begin
              w_mem_en = 1'b1;
              w_mem_we = cpu_we;
            end
          end else if (w_aux_go) begin
            w_issue      = 1'b1;
            w_owner      = OWN_AUX;
            w_last_grant = 1'b1;
            w_mem_en     = 1'b1;
            w_mem_addr   = aux_addr;
          end
        end
      end
      default: w_state = ST_FONT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= ST_FONT;
      r_owner      <= OWN_ROM;
      r_font_idx   <= '0;
      r_issue      <= 1'b0;
      r_last_grant <= 1'b1;
      r_done_pend  <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rom_ack    <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_aux_ack    <= 1'b0;
      r_font_ready <= 1'b0;
      r_sys_ready  <= 1'b0;
      r_prot_err   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_font_idx   <= w_font_idx;
      r_issue      <= w_issue;
      r_last_grant <= w_last_grant;
      r_done_pend  <= w_done_pend;
      r_mem_en     <= w_mem_en;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_rom_ack    <= w_rom_ack;
      r_cpu_ack    <= w_cpu_ack;
      r_aux_ack    <= w_aux_ack;
      r_font_ready <= w_font_ready;
      r_sys_ready  <= w_sys_ready;
      r_prot_err   <= w_prot_err;
    end
  end

  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign rom_ack      = r_rom_ack;
  assign cpu_ack      = r_cpu_ack;
  assign aux_ack      = r_aux_ack;
  // Read data arrives from memory in the ack cycle itself, so it is passed through gated.
  assign cpu_rdata    = r_cpu_ack ? mem_rdata : 8'h00;
  assign aux_rdata    = r_aux_ack ? mem_rdata : 8'h00;
  assign font_ready   = r_font_ready;
  assign system_ready = r_sys_ready;
  assign prot_err     = r_prot_err;

endmodule

// File: tb/tb_chip8_mem_sched.sv
// Directed bench for chip8_mem_sched with a behavioural 4096x8 synchronous memory.
module tb_chip8_mem_sched;

`ifdef CHIP8_MEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rom_req, rom_done, rom_ack;
  logic [11:0] rom_addr;
  logic [7:0]  rom_wdata;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        aux_req, aux_ack;
  logic [11:0] aux_addr;
  logic [7:0]  aux_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        font_ready, system_ready, prot_err;

  logic [7:0] mem [0:4095];
  int n_chk = 0;
  int n_err = 0;

  logic [7:0] font [0:79] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  chip8_mem_sched dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .rom_done(rom_done), .rom_ack(rom_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .font_ready(font_ready), .system_ready(system_ready), .prot_err(prot_err)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                            input logic exp_en, output logic [7:0] rd);
    int lat;
    logic saw_en, saw_we;
    logic [11:0] saw_addr;
    logic [7:0] saw_wd;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0; saw_en = 1'b0; saw_we = 1'b0; saw_addr = '0; saw_wd = '0;
    while (!cpu_ack && lat < 10) begin
      step();
      lat++;
      if (mem_en) begin
        saw_en = 1'b1; saw_we = mem_we; saw_addr = mem_addr; saw_wd = mem_wdata;
      end
    end
    rd = cpu_rdata;
    chk("cpu_latency", 32'(lat), 32'd2);
    chk("cpu_mem_en", 32'(saw_en), 32'(exp_en));
    chk("cpu_mem_cmd", 32'({saw_we, saw_addr, (we ? saw_wd : 8'h00)}),
        exp_en ? 32'({we, addr, (we ? wd : 8'h00)}) : 32'd0);
    cpu_req = 1'b0;
    step();
    chk("cpu_ack_single", 32'(cpu_ack), 32'd0);
  endtask

  task automatic aux_read(input logic [11:0] addr, output logic [7:0] rd);
    int lat;
    logic saw_en, saw_we;
    logic [11:0] saw_addr;
    aux_req = 1'b1; aux_addr = addr;
    lat = 0; saw_en = 1'b0; saw_we = 1'b0; saw_addr = '0;
    while (!aux_ack && lat < 10) begin
      step();
      lat++;
      if (mem_en) begin
        saw_en = 1'b1; saw_we = mem_we; saw_addr = mem_addr;
      end
    end
    rd = aux_rdata;
    chk("aux_latency", 32'(lat), 32'd2);
    chk("aux_mem_cmd", 32'({saw_en, saw_we, saw_addr}), 32'({1'b1, 1'b0, addr}));
    aux_req = 1'b0;
    step();
    chk("aux_ack_single", 32'(aux_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [1:0] ph;
    logic [3:0]  e_ctl;
    logic [11:0] e_addr;
    logic [15:0] e_data;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    rst_in = 1'b0;
    rom_req = 1'b0; rom_done = 1'b0; rom_addr = '0; rom_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 1'b0; aux_addr = '0;
    step();
    step();
    chk("reset_outputs", 32'({mem_en, mem_we, mem_addr, mem_wdata, rom_ack, cpu_ack, aux_ack}), 32'd0);
    chk("reset_status", 32'({cpu_rdata, aux_rdata, font_ready, system_ready, prot_err}), 32'd0);

    // Both requesters pending from the start: nothing may be served before RUN.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    aux_req = 1'b1; aux_addr = 12'h005;
    rst_in = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      chk("font_write", 32'({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, aux_ack, rom_ack, font_ready}),
          32'({1'b1, 1'b1, 12'(i), font[i], 4'b0000}));
    end
    step();
    chk("font_ready", 32'(font_ready), 32'd1);
    chk("rom_idle", 32'({mem_en, cpu_ack, aux_ack, system_ready}), 32'd0);

    rom_req = 1'b1; rom_addr = 12'h200; rom_wdata = 8'h6A;
    step();
    chk("rom_issue", 32'({mem_en, mem_we, mem_addr, mem_wdata, rom_ack}), 32'({1'b1, 1'b1, 12'h200, 8'h6A, 1'b0}));
    step();
    chk("rom_ack", 32'({rom_ack, mem_en, cpu_ack, aux_ack}), 32'b1000);
    rom_req = 1'b0; rom_done = 1'b1;
    step();
    rom_done = 1'b0;
    chk("system_ready", 32'(system_ready), 32'd1);
    chk("run_entry_quiet", 32'({mem_en, cpu_ack, aux_ack, rom_ack}), 32'd0);

    // Held CPU+aux: CPU wins the first tie, then strict alternation.
    for (int k = 0; k < 8; k++) begin
      step();
      ph = 2'(k % 4);
      case (ph)
        2'd0:    begin e_ctl = 4'b1000; e_addr = 12'h200; e_data = 16'h0000; end
        2'd1:    begin e_ctl = 4'b0010; e_addr = 12'h000; e_data = 16'h6A00; end
        2'd2:    begin e_ctl = 4'b1000; e_addr = 12'h005; e_data = 16'h0000; end
        default: begin e_ctl = 4'b0001; e_addr = 12'h000; e_data = 16'h0020; end
      endcase
      chk("rr_ctl", 32'({mem_en, mem_we, cpu_ack, aux_ack}), 32'(e_ctl));
      chk("rr_addr", 32'(mem_en ? mem_addr : 12'h000), 32'(e_addr));
      chk("rr_data", 32'({(cpu_ack ? cpu_rdata : 8'h00), (aux_ack ? aux_rdata : 8'h00)}), 32'(e_data));
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    step();

    rom_req = 1'b1; rom_addr = 12'h123; rom_wdata = 8'h55;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rom_in_run", 32'({rom_ack, mem_en}), 32'd0);
    end
    rom_req = 1'b0;
    step();

    cpu_access(1'b1, 12'h300, 8'h12, 1'b1, rd);
    chk("prot_err_high_addr", 32'(prot_err), 32'd0);
    cpu_access(1'b0, 12'h300, 8'h00, 1'b1, rd);
    chk("cpu_readback_300", 32'(rd), 32'h12);
    cpu_access(1'b1, 12'hFFF, 8'hA5, 1'b1, rd);
    aux_read(12'hFFF, rd);
    chk("aux_read_fff", 32'(rd), 32'hA5);
    aux_read(12'h04F, rd);
    chk("aux_read_font_last", 32'(rd), 32'h80);

    cpu_access(1'b1, 12'h050, 8'hFF, !WP, rd);
    chk("prot_err", 32'(prot_err), 32'(WP));
    cpu_access(1'b0, 12'h050, 8'h00, 1'b1, rd);
    chk("cpu_readback_050", 32'(rd), WP ? 32'h00 : 32'hFF);

    // Asynchronous reset while a CPU read is on the memory port.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
    step();
    chk("pre_reset_issue", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 12'h300}));
    #2 rst_in = 1'b0;
    #1;
    chk("async_reset", 32'({mem_en, cpu_ack, system_ready, font_ready, prot_err}), 32'd0);
    cpu_req = 1'b0;
    step();
    chk("reset_no_ack", 32'({cpu_ack, mem_en}), 32'd0);
    step();
    rst_in = 1'b1;
    step();
    chk("refont_0", 32'({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack}), 32'({1'b1, 1'b1, 12'h000, 8'hF0, 1'b0}));
    step();
    chk("refont_1", 32'({mem_en, mem_we, mem_addr, mem_wdata, system_ready}), 32'({1'b1, 1'b1, 12'h001, 8'h90, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/chip8_mem_sched.md
Name: chip8_mem_sched

Overview:
- Boot sequencer and access scheduler for the 4096x8 CHIP-8 main memory, owning its single synchronous port.
- After reset, it writes the 80-byte hex fontset itself, then hands the port to the ROM loader, then enters RUN.
- In RUN it arbitrates round-robin between the CPU and an auxiliary read port (GPU sprite fetch / debug).
- Replaces the ad-hoc font/ROM initialisation and readiness gating in the top level; drives system_ready.

Parameters:
ADDR_W, 12, memory address width (4096 bytes)
FONT_BASE, 12'h000, address of first font byte; font occupies FONT_BASE..FONT_BASE+79
PROTECT_TOP, 12'h1FF, highest protected address for the optional feature

Ports:
clk_in  in  1  system clock, all logic on rising edge
rst_in  in  1  asynchronous active-low reset
rom_req  in  1  ROM loader write request, held until rom_ack
rom_addr  in  ADDR_W  ROM write address
rom_wdata  in  8  ROM write data
rom_done  in  1  one-cycle pulse: ROM image fully written
rom_ack  out  1  one-cycle pulse: ROM write committed
cpu_req  in  1  CPU access request, held with fields stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle pulse: write done / cpu_rdata valid
cpu_rdata  out  8  read data, valid only while cpu_ack
aux_req  in  1  auxiliary read request, held until aux_ack
aux_addr  in  ADDR_W  auxiliary read address
aux_ack  out  1  one-cycle pulse: aux_rdata valid
aux_rdata  out  8  read data, valid only while aux_ack
mem_en  out  1  memory port enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, one cycle after mem_en with mem_we=0
font_ready  out  1  font table written
system_ready  out  1  boot complete; CPU may run
prot_err  out  1  sticky protection violation (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst_in low, asynchronous): state FONT; font counter 0; all outputs 0, including mem_en, mem_we, acks, rdata, font_ready, system_ready and prot_err. Any in-flight transaction is dropped with no ack; requesters must re-request.
- mem_* outputs are registered. The memory is single-port, synchronous, with 1-cycle read latency.
- FONT: one write per cycle, mem_addr = FONT_BASE+i, mem_wdata = standard CHIP-8 fontset byte i (0:F0 90 90 90 F0 ... F:F0 80 F0 80 80), i = 0..79. After the write of i=79, font_ready=1 the next cycle and the state moves to ROM. FONT takes exactly 80 cycles after reset release.
- ROM: while rom_req is high, issue the write and pulse rom_ack on the cycle after mem_en. Transactions are at most one per 2 cycles. A rom_done pulse moves the state to RUN; if a write is in flight, RUN is entered after its ack. system_ready=1 from the first RUN cycle and stays 1 until reset.
- RUN: a transaction is IDLE -> ISSUE (mem_* driven, one cycle) -> RESP (ack pulsed, rdata captured from mem_rdata).
  - Requesters are sampled only in IDLE.
  - Round-robin between CPU and aux: a last_grant bit favours the other requester when both are pending. last_grant resets to aux, so the CPU wins the first tie.
  - Aux is read-only; mem_we is forced to 0 for aux.
- Requests outside their phase are never acked and never reach memory: cpu_req/aux_req before RUN; rom_req in FONT or RUN. rom_done outside ROM is ignored.
- Addresses are ADDR_W bits; there is no wrap logic, and the full range 0..4095 is valid.
- mem_en is deasserted in every cycle with no issue. Acks are never asserted in consecutive cycles for the same requester.

Optional Feature:
- Macro: CHIP8_MEM_WRITE_PROTECT_EN.
- Defined: in RUN, a CPU write with cpu_addr <= PROTECT_TOP is not issued to memory (mem_en stays 0). cpu_ack is still pulsed at the normal cycle, and prot_err is set sticky until reset.
- Undefined: CPU writes to any address are performed and prot_err is constant 0.

Test Plan:
- Reset release, no requests -> 80 consecutive writes of F0,90,90,90,F0,...,80 to 0x000-0x04F; font_ready=1 at cycle 81; no acks.
- In ROM, rom_req addr 0x200 data 0x6A, then rom_done -> mem write 0x200=0x6A, rom_ack 2 cycles after req sampled; system_ready=1 on entry to RUN; cpu_req asserted earlier gets no ack before RUN.
- RUN, CPU read 0x200 -> mem_en read issued, cpu_ack with cpu_rdata=0x6A; CPU write 0x300=0x12, then read back -> 0x12.
- RUN, cpu_req and aux_req held high together -> grants alternate CPU, aux, CPU, aux; each ack spaced 2 cycles; aux never drives mem_we=1.
- Pull rst_in low during a CPU read ISSUE cycle -> mem_en=0 immediately, no cpu_ack, system_ready=0; after release, the font load restarts at address 0x000.
- With CHIP8_MEM_WRITE_PROTECT_EN, CPU write 0x050=0xFF -> no mem write, cpu_ack pulsed, prot_err=1; a later read of 0x050 returns the unchanged value.
